rgb2raw_mosaic: RTL

//  Re-mosaics a demosaiced 12-bit RGB pixel stream back into a single-channel Bayer RAW stream.

---
 rtl/camera_pkg.sv | 17 +
 rtl/rgb2raw_mosaic_if.sv | 23 ++
 rtl/pixel_xy_counter.sv | 40 ++++
 rtl/rgb2raw_mosaic.sv | 63 ++++++
 4 files changed

// File: rtl/camera_pkg.sv
// camera_pkg: shared Bayer phase/channel types, pixel width and CFA channel lookup
package camera_pkg;
    localparam int PIX_W = 12;
    typedef enum logic [1:0] {GRBG, RGGB, BGGR, GBRG} bayer_e;
    typedef enum logic [1:0] {CH_R, CH_G, CH_B} chan_e;
    // phase = {Y[0], X[0]}; diagonal phases (00/11) are the same colour family
    function automatic chan_e bayer_chan(bayer_e bayer, logic [1:0] phase);
        logic diag;
        diag = phase[1] == phase[0];
        case (bayer)
            GRBG:    bayer_chan = diag ? CH_G : (phase[0] ? CH_R : CH_B);
            RGGB:    bayer_chan = !diag ? CH_G : (phase[0] ? CH_B : CH_R);
            BGGR:    bayer_chan = !diag ? CH_G : (phase[0] ? CH_R : CH_B);
            default: bayer_chan = diag ? CH_G : (phase[0] ? CH_B : CH_R);
        endcase
    endfunction
endpackage

// File: rtl/rgb2raw_mosaic_if.sv
// rgb2raw_mosaic_if: RGB pixel input and Bayer RAW output bundle
interface rgb2raw_mosaic_if;
    import camera_pkg::*;
    logic             iSOF;
    logic             iDVAL;
    logic [PIX_W-1:0] iRed;
    logic [PIX_W-1:0] iGreen;
    logic [PIX_W-1:0] iBlue;
    logic [PIX_W-1:0] oDATA;
    logic             oDVAL;
    logic [15:0]      oX_Cont;
    logic [15:0]      oY_Cont;
    logic [15:0]      oFrame_Cont;
    logic             oSync_Err;
    modport master (
        output iSOF, iDVAL, iRed, iGreen, iBlue,
        input  oDATA, oDVAL, oX_Cont, oY_Cont, oFrame_Cont, oSync_Err
    );
    modport slave (
        input  iSOF, iDVAL, iRed, iGreen, iBlue,
        output oDATA, oDVAL, oX_Cont, oY_Cont, oFrame_Cont, oSync_Err
    );
endinterface

// File: rtl/pixel_xy_counter.sv
// pixel_xy_counter: X/Y/frame counters with SOF realignment and sticky frame-sync error
module pixel_xy_counter #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480
) (
    input  logic        iCLK,
    input  logic        iRST,
    input  logic        iSOF,
    input  logic        iDVAL,
    output logic [15:0] oX,
    output logic [15:0] oY,
    output logic [15:0] oFrame_Cont,
    output logic        oSync_Err
);
    logic [15:0] xCnt, yCnt;
    logic sofHit, lastX, lastY;
    // oX/oY are the coordinates of the pixel being accepted this cycle
    always_comb begin
        sofHit = iSOF && iDVAL;
        oX     = sofHit ? '0 : xCnt;
        oY     = sofHit ? '0 : yCnt;
        lastX  = oX == 16'(H_ACTIVE - 1);
        lastY  = oY == 16'(V_ACTIVE - 1);
    end
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            xCnt        <= '0;
            yCnt        <= '0;
            oFrame_Cont <= '0;
            oSync_Err   <= 1'b0;
        end else if (iDVAL) begin
            xCnt <= lastX ? '0 : oX + 16'd1;
            yCnt <= lastX ? (lastY ? '0 : oY + 16'd1) : oY;
            if (lastX && lastY)
                oFrame_Cont <= oFrame_Cont + 16'd1;
            if (sofHit && (xCnt != '0 || yCnt != '0))
                oSync_Err <= 1'b1;
        end
    end
endmodule

// File: rtl/rgb2raw_mosaic.sv
// rgb2raw_mosaic: re-mosaics a 12-bit RGB stream into Bayer RAW with aligned X/Y/frame outputs
module rgb2raw_mosaic import camera_pkg::*; #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int BAYER    = 0
) (
    input logic             iCLK,
    input logic             iRST,
    rgb2raw_mosaic_if.slave bus
);
    localparam bayer_e CFA = bayer_e'(BAYER[1:0]);
    logic [15:0] xCur, yCur, frameCnt, s1X, s1Y;
    logic syncErr, s1Dval;
    chan_e s1Sel;
    logic [PIX_W-1:0] s1Red, s1Green, s1Blue, rawPix;
    pixel_xy_counter #(.H_ACTIVE(H_ACTIVE), .V_ACTIVE(V_ACTIVE)) u_xy (
        .iCLK(iCLK),
        .iRST(iRST),
        .iSOF(bus.iSOF),
        .iDVAL(bus.iDVAL),
        .oX(xCur),
        .oY(yCur),
        .oFrame_Cont(frameCnt),
        .oSync_Err(syncErr)
    );
    always_comb rawPix = s1Sel == CH_R ? s1Red : s1Sel == CH_B ? s1Blue : s1Green;
    // frame count and sync error take one register here so they land with oDVAL
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            s1Dval          <= 1'b0;
            s1Sel           <= CH_R;
            s1Red           <= '0;
            s1Green         <= '0;
            s1Blue          <= '0;
            s1X             <= '0;
            s1Y             <= '0;
            bus.oDVAL       <= 1'b0;
            bus.oDATA       <= '0;
            bus.oX_Cont     <= '0;
            bus.oY_Cont     <= '0;
            bus.oFrame_Cont <= '0;
            bus.oSync_Err   <= 1'b0;
        end else begin
            s1Dval          <= bus.iDVAL;
            bus.oDVAL       <= s1Dval;
            bus.oFrame_Cont <= frameCnt;
            bus.oSync_Err   <= syncErr;
            if (bus.iDVAL) begin
                s1Sel   <= bayer_chan(CFA, {yCur[0], xCur[0]});
                s1Red   <= bus.iRed;
                s1Green <= bus.iGreen;
                s1Blue  <= bus.iBlue;
                s1X     <= xCur;
                s1Y     <= yCur;
            end
            if (s1Dval) begin
                bus.oDATA   <= rawPix;
                bus.oX_Cont <= s1X;
                bus.oY_Cont <= s1Y;
            end
        end
    end
endmodule
